// File: rtl/mux_pkg.sv
// Shared definitions for the N-channel stream multiplexer and its arbiter.
package mux_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    typedef enum logic {
        MUX_MODE_SEL = 1'b0,
        MUX_MODE_RR  = 1'b1
    } mux_mode_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after ptr, wrapping modulo NUM_CH.
module rr_arbiter #(
    parameter int NUM_CH = 8,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  idx,
    output logic              any
);

    always_comb begin : search
        int cand;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        // Offsets 1..NUM_CH so the previous winner is considered last.
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = (int'(ptr) + k) % NUM_CH;
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/mux_n_arb.sv
// N-channel valid/ready stream multiplexer with a registered output stage,
// selecting either by the sel port or round-robin over valid channels.
module mux_n_arb
    import mux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 8,
    parameter int SEL_W  = $clog2(NUM_CH),
    parameter int MODE   = MODE_SEL
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [SEL_W-1:0]         sel,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SEL_W-1:0]         out_ch
);

    logic [DATA_W-1:0] out_data_reg;
    logic              out_valid_reg;
    logic [SEL_W-1:0]  out_ch_reg;

    logic [NUM_CH-1:0] grant;
    logic [SEL_W-1:0]  grant_idx;
    logic              grant_any;
    logic              load_en;
    logic              transfer;
    logic [DATA_W-1:0] grant_data;

    assign load_en  = !out_valid_reg || out_ready;
    assign transfer = !rst && load_en && grant_any;

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [SEL_W-1:0] rr_ptr_reg;

            rr_arbiter #(
                .NUM_CH (NUM_CH),
                .IDX_W  (SEL_W)
            ) u_arb (
                .req   (in_valid),
                .ptr   (rr_ptr_reg),
                .grant (grant),
                .idx   (grant_idx),
                .any   (grant_any)
            );

            // Reset value NUM_CH-1 makes the first search start at channel 0.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rr_ptr_reg <= SEL_W'(NUM_CH - 1);
                end else if (transfer) begin
                    rr_ptr_reg <= grant_idx;
                end
            end
        end else begin : g_sel
            // An out-of-range sel matches no channel, so nothing is granted.
            for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_dec
                assign grant[gi] = in_valid[gi] && (sel == SEL_W'(gi));
            end
            assign grant_idx = sel;
            assign grant_any = |grant;
        end
    endgenerate

    assign grant_data = in_data[int'(grant_idx)*DATA_W +: DATA_W];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ready
        assign in_ready[gi] = !rst && load_en && grant[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_ch_reg    <= '0;
        end else if (load_en) begin
            out_valid_reg <= transfer;
            if (transfer) begin
                out_data_reg <= grant_data;
                out_ch_reg   <= grant_idx;
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign out_ch    = out_ch_reg;

endmodule

// File: tb/tb_mux_n_arb.sv
// Directed bench for mux_n_arb: two fixed-select instances (8 and 6 channels)
// and one round-robin instance, checked against a scoreboard of expected words.
module tb_mux_n_arb;
    import mux_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: MODE_SEL, 8 channels
    logic [63:0] a_in_data;
    logic [7:0]  a_in_valid, a_in_ready;
    logic [2:0]  a_sel, a_out_ch;
    logic [7:0]  a_out_data;
    logic        a_out_valid, a_out_ready;
    // Instance B: MODE_SEL, 6 channels
    logic [47:0] b_in_data;
    logic [5:0]  b_in_valid, b_in_ready;
    logic [2:0]  b_sel, b_out_ch;
    logic [7:0]  b_out_data;
    logic        b_out_valid, b_out_ready;
    // Instance C: MODE_RR, 8 channels
    logic [63:0] c_in_data;
    logic [7:0]  c_in_valid, c_in_ready;
    logic [2:0]  c_sel, c_out_ch;
    logic [7:0]  c_out_data;
    logic        c_out_valid, c_out_ready;

    mux_n_arb #(.DATA_W(8), .NUM_CH(8), .MODE(MODE_SEL)) dut_a (
        .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .sel(a_sel), .out_data(a_out_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ch(a_out_ch));

    mux_n_arb #(.DATA_W(8), .NUM_CH(6), .MODE(MODE_SEL)) dut_b (
        .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .sel(b_sel), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ch(b_out_ch));

    mux_n_arb #(.DATA_W(8), .NUM_CH(8), .MODE(MODE_RR)) dut_c (
        .clk(clk), .rst(rst), .in_data(c_in_data), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .sel(c_sel), .out_data(c_out_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_ch(c_out_ch));

    typedef struct {
        logic [7:0] data;
        logic [2:0] ch;
    } sb_t;
    sb_t sb_q[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic [2:0] c);
        sb_t e;
        e.data = d;
        e.ch   = c;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input string tag, input logic ov, input logic [7:0] od,
                             input logic [2:0] oc);
        sb_t e;
        chk({tag, ".valid"}, 32'(ov), 32'd1);
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s.sb: observed output word %0h but expected no word", tag, od);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".data"}, 32'(od), 32'(e.data));
            chk({tag, ".ch"},   32'(oc), 32'(e.ch));
        end
        $display("txn %s: data=%0h ch=%0d", tag, od, oc);
    endtask

    initial begin
        logic [7:0] d;
        logic [2:0] exp_ch;
        logic [2:0] sel_list [4];
        logic [2:0] rr_part  [4];
        sel_list = '{3'd0, 3'd5, 3'd7, 3'd2};
        rr_part  = '{3'd2, 3'd5, 3'd7, 3'd2};

        // 1: reset held 3 cycles with every channel valid
        a_in_data = '0; b_in_data = '0; c_in_data = '0;
        a_in_valid = '1; b_in_valid = '1; c_in_valid = '1;
        a_sel = 3'd0; b_sel = 3'd0; c_sel = 3'd0;
        a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;
        rst = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("rst.a_valid", 32'(a_out_valid), 32'd0);
            chk("rst.a_data",  32'(a_out_data),  32'd0);
            chk("rst.a_ready", 32'(a_in_ready),  32'd0);
            chk("rst.c_valid", 32'(c_out_valid), 32'd0);
            chk("rst.c_ready", 32'(c_in_ready),  32'd0);
            if (i < 2) tick();
        end
        a_in_valid = '0; b_in_valid = '0; c_in_valid = '0;
        rst = 1'b0;
        tick();

        // 2: fixed select, single valid channel then several sel values
        for (int i = 0; i < 8; i++) a_in_data[i*8 +: 8] = 8'($urandom);
        a_in_data[3*8 +: 8] = 8'hA5;
        a_in_valid = 8'b0000_1000;
        a_sel = 3'd3;
        #1;
        chk("sel3.ready", 32'(a_in_ready), 32'h08);
        push(8'hA5, 3'd3);
        tick();
        a_in_valid = '0;
        pop_check("sel3", a_out_valid, a_out_data, a_out_ch);
        foreach (sel_list[k]) begin
            for (int i = 0; i < 8; i++) a_in_data[i*8 +: 8] = 8'($urandom);
            a_in_valid = 8'hFF;
            a_sel = sel_list[k];
            d = a_in_data[int'(sel_list[k])*8 +: 8];
            #1;
            chk("selseq.ready", 32'(a_in_ready), 32'(8'h01 << sel_list[k]));
            push(d, sel_list[k]);
            tick();
            pop_check("selseq", a_out_valid, a_out_data, a_out_ch);
        end
        // selected channel not valid: no grant, output drains
        a_in_valid = 8'b1111_0111;
        a_sel = 3'd3;
        #1;
        chk("selnv.ready", 32'(a_in_ready), 32'd0);
        tick();
        chk("selnv.valid", 32'(a_out_valid), 32'd0);
        a_in_valid = '0;

        // 3: six channels, sel beyond range never grants
        for (int i = 0; i < 6; i++) b_in_data[i*8 +: 8] = 8'h60 + 8'(i);
        b_in_valid = 6'h3F;
        b_sel = 3'd7;
        #1;
        chk("oor7.ready", 32'(b_in_ready), 32'd0);
        tick();
        chk("oor7.valid", 32'(b_out_valid), 32'd0);
        b_sel = 3'd6;
        #1;
        chk("oor6.ready", 32'(b_in_ready), 32'd0);
        tick();
        chk("oor6.valid", 32'(b_out_valid), 32'd0);
        b_sel = 3'd5;
        #1;
        chk("b5.ready", 32'(b_in_ready), 32'h20);
        push(8'h65, 3'd5);
        tick();
        b_in_valid = '0;
        pop_check("b5", b_out_valid, b_out_data, b_out_ch);

        // 5: backpressure holds the output word and blocks inputs
        a_in_data[1*8 +: 8] = 8'h3C;
        a_in_valid = 8'b0000_0010;
        a_sel = 3'd1;
        a_out_ready = 1'b1;
        #1;
        push(8'h3C, 3'd1);
        tick();
        pop_check("bp.load", a_out_valid, a_out_data, a_out_ch);
        a_out_ready = 1'b0;
        a_in_data[6*8 +: 8] = 8'h5A;
        a_in_valid = 8'hFF;
        a_sel = 3'd6;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp.ready", 32'(a_in_ready), 32'd0);
            tick();
            chk("bp.valid", 32'(a_out_valid), 32'd1);
            chk("bp.data",  32'(a_out_data),  32'h3C);
            chk("bp.ch",    32'(a_out_ch),    32'd1);
        end
        a_out_ready = 1'b1;
        #1;
        chk("bp.release", 32'(a_in_ready), 32'h40);
        push(8'h5A, 3'd6);
        tick();
        a_in_valid = '0;
        pop_check("bp.reload", a_out_valid, a_out_data, a_out_ch);

        // 4: round-robin, all channels valid, then a sparse request set
        for (int i = 0; i < 8; i++) c_in_data[i*8 +: 8] = 8'h10 + 8'(i);
        c_in_valid = 8'hFF;
        c_sel = 3'd4;
        for (int k = 0; k < 9; k++) begin
            exp_ch = 3'(k % 8);
            #1;
            chk("rr.ready", 32'(c_in_ready), 32'(8'h01 << exp_ch));
            push(8'h10 + 8'(exp_ch), exp_ch);
            tick();
            pop_check("rr", c_out_valid, c_out_data, c_out_ch);
        end
        c_in_valid = 8'b1010_0100;
        foreach (rr_part[k]) begin
            #1;
            chk("rrp.ready", 32'(c_in_ready), 32'(8'h01 << rr_part[k]));
            push(8'h10 + 8'(rr_part[k]), rr_part[k]);
            tick();
            pop_check("rrp", c_out_valid, c_out_data, c_out_ch);
        end

        // 6: reset right after ch5 is granted
        c_in_valid = 8'b0010_0000;
        #1;
        chk("rr5.ready", 32'(c_in_ready), 32'h20);
        push(8'h15, 3'd5);
        tick();
        pop_check("rr5", c_out_valid, c_out_data, c_out_ch);
        c_in_valid = 8'hFF;
        rst = 1'b1;
        #1;
        chk("mrst.ready", 32'(c_in_ready), 32'd0);
        tick();
        chk("mrst.valid", 32'(c_out_valid), 32'd0);
        rst = 1'b0;
        #1;
        chk("mrst.first", 32'(c_in_ready), 32'h01);
        push(8'h10, 3'd0);
        tick();
        c_in_valid = '0;
        pop_check("mrst.ch0", c_out_valid, c_out_data, c_out_ch);

        if (sb_q.size() != 0) begin
            n_vec++;
            n_err++;
            $error("FAIL sb.drain: observed %0d words left, expected 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
